// File: rtl/adder_share_arbiter.sv
// ============================================================================
//  Module      : adder_share_arbiter
//  Description : Round-robin arbiter that shares one WIDTH-bit adder among
//                NUM_REQ requesters, with a registered valid/ready result.
//                Define ADDER_ARB_FLAGS_EN to add rsp_carry / rsp_ovf outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] first_in,
    input  logic [NUM_REQ*WIDTH-1:0] second_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     busy
`ifdef ADDER_ARB_FLAGS_EN
    ,
    output logic                     rsp_carry,
    output logic                     rsp_ovf
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;
    localparam logic [ID_W-1:0] C_PTR_RESET = ID_W'(NUM_REQ - 1);

    logic [0:0]       r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [WIDTH-1:0] r_sum;

    logic             w_can_accept;
    logic             w_any;
    logic             w_fire;
    logic [ID_W-1:0]  w_idx;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;

    // Requester index k positions after the pointer, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;

    // Scan farthest-first so the nearest set request after the pointer wins.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[rr_idx(r_ptr, k)]) begin
                w_any = 1'b1;
                w_idx = rr_idx(r_ptr, k);
            end
        end
    end

    assign w_fire = w_can_accept && w_any && !reset;
    assign w_a    = first_in[int'(w_idx)*WIDTH +: WIDTH];
    assign w_b    = second_in[int'(w_idx)*WIDTH +: WIDTH];

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_gnt
            assign gnt[i] = w_fire && (w_idx == ID_W'(i));
        end
    endgenerate

`ifdef ADDER_ARB_FLAGS_EN
    logic [WIDTH:0] w_sum_ext;
    logic           w_ovf;
    logic           r_carry;
    logic           r_ovf;

    assign w_sum_ext = {1'b0, w_a} + {1'b0, w_b};
    assign w_sum     = w_sum_ext[WIDTH-1:0];
    // Signed overflow: like-signed operands producing an opposite-signed sum.
    assign w_ovf     = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_fire) begin
            r_carry <= w_sum_ext[WIDTH];
            r_ovf   <= w_ovf;
        end
    end

    assign rsp_carry = r_carry;
    assign rsp_ovf   = r_ovf;
`else
    assign w_sum = w_a + w_b;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_ptr   <= C_PTR_RESET;
            r_id    <= '0;
            r_sum   <= '0;
        end else if (w_fire) begin
            // A grant in FULL drains the old result and loads the new one together.
            r_state <= ST_FULL;
            r_ptr   <= w_idx;
            r_id    <= w_idx;
            r_sum   <= w_sum;
        end else if ((r_state == ST_FULL) && rsp_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign busy      = rsp_valid && !rsp_ready;

endmodule

`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
// ============================================================================
//  Module      : tb_adder_share_arbiter
//  Description : Directed self-checking bench for adder_share_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int WIDTH   = 32;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] first_in;
    logic [NUM_REQ*WIDTH-1:0] second_in;
    logic [NUM_REQ-1:0]       gnt;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     busy;
`ifdef ADDER_ARB_FLAGS_EN
    logic                     rsp_carry;
    logic                     rsp_ovf;
`endif

    int n_pass;
    int n_total;

    adder_share_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .WIDTH  (WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .first_in (first_in),
        .second_in(second_in),
        .gnt      (gnt),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .busy     (busy)
`ifdef ADDER_ARB_FLAGS_EN
        ,
        .rsp_carry(rsp_carry),
        .rsp_ovf  (rsp_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        first_in[i*WIDTH +: WIDTH]  = a;
        second_in[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req       = 4'b1111;
        rsp_ready = 1'b1;
        first_in  = '0;
        second_in = '0;
        tick();
        n_total++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", gnt);
        else n_pass++;
        n_total++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rsp_valid);
        else n_pass++;
        n_total++;
        if (rsp_id !== 2'd0) $display("FAIL reset_id: got %0d expected 0", rsp_id);
        else n_pass++;
        n_total++;
        if (rsp_sum !== 32'd0) $display("FAIL reset_sum: got %h expected 0", rsp_sum);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else n_pass++;
`ifdef ADDER_ARB_FLAGS_EN
        n_total++;
        if ({rsp_carry, rsp_ovf} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {rsp_carry, rsp_ovf});
        else n_pass++;
`endif
        req = '0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_single();
        req       = 4'b0001;
        rsp_ready = 1'b1;
        set_op(0, 32'd45, 32'd89654);
        #1;
        n_total++;
        if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b expected 0001", gnt);
        else n_pass++;
        tick();
        req = 4'b0000;
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'd89699)
            $display("FAIL single_rsp: got v=%b id=%0d sum=%0d expected v=1 id=0 sum=89699",
                     rsp_valid, rsp_id, rsp_sum);
        else n_pass++;
        tick();
        n_total++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 32'd89699 || rsp_id !== 2'd0)
            $display("FAIL single_drain: got v=%b id=%0d sum=%0d expected v=0 id=0 sum=89699",
                     rsp_valid, rsp_id, rsp_sum);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int          exp_id [5];
        logic [31:0] exp_sum[4];
        exp_id  = '{0, 1, 2, 3, 0};
        exp_sum = '{32'd65498, 32'd20349, 32'd2, 32'd30};
        do_reset();
        set_op(0, 32'd0, 32'd65498);
        set_op(1, 32'd7984, 32'd12365);
        set_op(2, 32'd1, 32'd1);
        set_op(3, 32'd10, 32'd20);
        req       = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_total++;
            if (gnt !== (4'b0001 << exp_id[k]))
                $display("FAIL rr_gnt[%0d]: got %b expected requester %0d", k, gnt, exp_id[k]);
            else n_pass++;
            tick();
            n_total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id[k]) || rsp_sum !== exp_sum[exp_id[k]])
                $display("FAIL rr_rsp[%0d]: got v=%b id=%0d sum=%0d expected v=1 id=%0d sum=%0d",
                         k, rsp_valid, rsp_id, rsp_sum, exp_id[k], exp_sum[exp_id[k]]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        // Holding 65498 from requester 0; pointer now at 0.
        req       = 4'b0010;
        rsp_ready = 1'b0;
        set_op(1, 32'd1000, 32'd2000);
        #1;
        n_total++;
        if (gnt !== 4'b0000 || busy !== 1'b1)
            $display("FAIL bp_stall: got gnt=%b busy=%b expected gnt=0000 busy=1", gnt, busy);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'd65498 || gnt !== 4'b0000)
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%0d gnt=%b expected v=1 id=0 sum=65498 gnt=0000",
                         k, rsp_valid, rsp_id, rsp_sum, gnt);
            else n_pass++;
        end
        rsp_ready = 1'b1;
        #1;
        n_total++;
        if (gnt !== 4'b0010 || busy !== 1'b0)
            $display("FAIL bp_release: got gnt=%b busy=%b expected gnt=0010 busy=0", gnt, busy);
        else n_pass++;
        tick();
        req = 4'b0000;
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 32'd3000)
            $display("FAIL bp_newrsp: got v=%b id=%0d sum=%0d expected v=1 id=1 sum=3000",
                     rsp_valid, rsp_id, rsp_sum);
        else n_pass++;
        tick();
    endtask

    task automatic test_overflow();
        // Pointer at 1, so requester 2 is scanned first.
        req       = 4'b0100;
        rsp_ready = 1'b1;
        set_op(2, 32'hFFFF_FFFF, 32'h0000_0001);
        #1;
        n_total++;
        if (gnt !== 4'b0100) $display("FAIL ovf_gnt: got %b expected 0100", gnt);
        else n_pass++;
        tick();
        set_op(2, 32'h7FFF_FFFF, 32'h0000_0001);
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'h0000_0000)
            $display("FAIL wrap_sum: got v=%b id=%0d sum=%h expected v=1 id=2 sum=00000000",
                     rsp_valid, rsp_id, rsp_sum);
        else n_pass++;
`ifdef ADDER_ARB_FLAGS_EN
        n_total++;
        if (rsp_carry !== 1'b1 || rsp_ovf !== 1'b0)
            $display("FAIL wrap_flags: got c=%b o=%b expected c=1 o=0", rsp_carry, rsp_ovf);
        else n_pass++;
`endif
        #1;
        n_total++;
        if (gnt !== 4'b0100) $display("FAIL repeat_gnt: got %b expected 0100", gnt);
        else n_pass++;
        tick();
        req = 4'b0000;
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'h8000_0000)
            $display("FAIL sovf_sum: got v=%b id=%0d sum=%h expected v=1 id=2 sum=80000000",
                     rsp_valid, rsp_id, rsp_sum);
        else n_pass++;
`ifdef ADDER_ARB_FLAGS_EN
        n_total++;
        if (rsp_carry !== 1'b0 || rsp_ovf !== 1'b1)
            $display("FAIL sovf_flags: got c=%b o=%b expected c=0 o=1", rsp_carry, rsp_ovf);
        else n_pass++;
`endif
    endtask

    task automatic test_deassert();
        // FULL with requester 2's result; withdraw a request before it is granted.
        rsp_ready = 1'b0;
        req       = 4'b1000;
        tick();
        req = 4'b0000;
        rsp_ready = 1'b1;
        #1;
        n_total++;
        if (gnt !== 4'b0000) $display("FAIL deassert_gnt: got %b expected 0000", gnt);
        else n_pass++;
        tick();
        n_total++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 32'h8000_0000 || rsp_id !== 2'd2)
            $display("FAIL deassert_rsp: got v=%b id=%0d sum=%h expected v=0 id=2 sum=80000000",
                     rsp_valid, rsp_id, rsp_sum);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        req = 4'b1000;
        set_op(3, 32'd5, 32'd6);
        tick();
        req       = 4'b0000;
        rsp_ready = 1'b0;
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 32'd11)
            $display("FAIL mid_full: got v=%b sum=%0d expected v=1 sum=11", rsp_valid, rsp_sum);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 32'd0 || rsp_id !== 2'd0)
            $display("FAIL mid_async: got v=%b id=%0d sum=%0d expected v=0 id=0 sum=0",
                     rsp_valid, rsp_id, rsp_sum);
        else n_pass++;
        tick();
        reset     = 1'b0;
        req       = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        n_total++;
        if (gnt !== 4'b0001) $display("FAIL mid_first_gnt: got %b expected 0001", gnt);
        else n_pass++;
        tick();
        req = 4'b0000;
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'd65498)
            $display("FAIL mid_first_rsp: got v=%b id=%0d sum=%0d expected v=1 id=0 sum=65498",
                     rsp_valid, rsp_id, rsp_sum);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_deassert();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
